// File: rtl/param_data_memory.sv
// Parametrised multi-cycle data memory with ready/done handshake and error flag.
// Define DMEM_BYTE_WRITE_EN to honour byteEnable per lane; otherwise stores write full words.
module param_data_memory #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   writeData,
    input  logic [DATA_WIDTH/8-1:0] byteEnable,
    input  logic                    MemRead,
    input  logic                    MemWrite,
    output logic [DATA_WIDTH-1:0]   readData,
    output logic                    ready,
    output logic                    done,
    output logic                    error
);

    localparam int unsigned NBytes = DATA_WIDTH / 8;
    localparam int unsigned OffW   = $clog2(NBytes);
    localparam int unsigned IdxW   = $clog2(DEPTH);
    localparam int unsigned CntW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [NBytes-1:0]       be_q, be_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    enter_done;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    misaligned, out_of_range, req_err;
    logic                    do_write, do_read;
    logic [IdxW-1:0]         word_idx;
    logic [NBytes-1:0]       lane_mask;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        enter_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (MemRead || MemWrite) begin
                    addr_d  = address;
                    wdata_d = writeData;
                    be_d    = byteEnable;
                    rd_d    = MemRead;
                    wr_d    = MemWrite;
                    if (LATENCY == 1) begin
                        state_d    = StDone;
                        enter_done = 1'b1;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = CntLoad;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    state_d    = StDone;
                    enter_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // The request being completed is the *_d view, which covers both LATENCY=1 and longer.
    assign misaligned   = |(addr_d & ADDR_WIDTH'(NBytes - 1));
    assign out_of_range = |(addr_d >> (OffW + IdxW));
    assign req_err      = misaligned | out_of_range | (rd_d & wr_d);
    assign word_idx     = addr_d[OffW +: IdxW];
    assign do_write     = enter_done & wr_d & ~req_err & ~rst;
    assign do_read      = enter_done & rd_d & ~req_err;

`ifdef DMEM_BYTE_WRITE_EN
    assign lane_mask = be_d;
`else
    assign lane_mask = be_d | {NBytes{1'b1}};
`endif

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (do_read) begin
            rdata_d = mem_q[word_idx];
        end
        if (enter_done) begin
            err_d = req_err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < NBytes; i++) begin
                if (lane_mask[i]) begin
                    mem_q[word_idx][8*i +: 8] <= wdata_d[8*i +: 8];
                end
            end
        end
    end

    assign ready    = (state_q == StIdle);
    assign done     = (state_q == StDone);
    assign error    = (state_q == StDone) & err_q;
    assign readData = rdata_q;

endmodule

// File: tb/tb_param_data_memory.sv
// Scoreboard bench for param_data_memory: byte-array reference model, randomized traffic.
module tb_param_data_memory;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int DEP = 64;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] address;
    logic [DW-1:0] writeData;
    logic [3:0]    byteEnable;
    logic          MemRead, MemWrite;
    logic [DW-1:0] readData;
    logic          ready, done, error;

    param_data_memory #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .address(address), .writeData(writeData),
        .byteEnable(byteEnable), .MemRead(MemRead), .MemWrite(MemWrite),
        .readData(readData), .ready(ready), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        bit          err;
        logic [31:0] rdata;
        string       name;
    } exp_t;

    exp_t        sb[$];
    byte unsigned mem_m [DEP*4];
    logic [31:0] last_rd = '0;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          low_run = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (rst) begin
            low_run = 0;
        end else begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, "_done_cycle"}, 32'(cyc), 32'(e.cyc));
                    check({e.name, "_error"}, 32'(error), 32'(e.err));
                    check({e.name, "_readData"}, readData, e.rdata);
                end
            end else if (error) begin
                check("error_without_done", 32'(error), 32'd0);
            end
            if (!ready) begin
                low_run++;
            end else begin
                if (low_run != 0) check("ready_low_cycles", 32'(low_run), 32'(LAT + 1));
                low_run = 0;
            end
        end
    end

    task automatic garbage();
        address    = $urandom;
        writeData  = $urandom;
        byteEnable = 4'($urandom);
        MemRead    = 1'($urandom);
        MemWrite   = 1'($urandom);
    endtask

    // Waits for ready, presents one request and records its expected outcome.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                          input bit rd, input bit wr, input string nm, input bit track);
        int  waited = 0;
        bit  err;
        @(negedge clk);
        while (!ready && waited < 50) begin
            garbage();
            @(negedge clk);
            waited++;
        end
        if (!ready) check({nm, "_ready_timeout"}, 32'(ready), 32'd1);
        address = a; writeData = wd; byteEnable = be; MemRead = rd; MemWrite = wr;
        if (track) begin
            err = (a % 4 != 0) || (a >= DEP * 4) || (rd && wr);
            if (!err && wr) begin
                for (int i = 0; i < 4; i++) begin
`ifdef DMEM_BYTE_WRITE_EN
                    if (be[i]) mem_m[a + i] = wd[8*i +: 8];
`else
                    mem_m[a + i] = wd[8*i +: 8];
`endif
                end
            end
            if (!err && rd) last_rd = {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
            sb.push_back('{cyc: cyc + 1 + LAT, err: err, rdata: last_rd, name: nm});
        end
    endtask

    task automatic drain();
        int waited = 0;
        @(negedge clk);
        while (!(ready && sb.size() == 0) && waited < 50) begin
            if (ready) begin
                MemRead = 1'b0; MemWrite = 1'b0;
            end else begin
                garbage();
            end
            @(negedge clk);
            waited++;
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        if (sb.size() != 0) check("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [31:0] model_word(input int a);
        return {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old4, a, wd;
        bit          rd, wr;
        rst = 1'b1; address = '0; writeData = '0; byteEnable = '0; MemRead = 0; MemWrite = 0;
        #12;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_error", 32'(error), 32'd0);
        check("reset_readData", readData, 32'd0);
        @(negedge clk); rst = 1'b0;

        for (int w = 0; w < DEP; w++) access(w * 4, $urandom, 4'hF, 0, 1, "fill", 1);

        access(4, 32'd23, 4'hF, 0, 1, "st4", 1);
        access(4, 32'h0, 4'h0, 1, 0, "ld4", 1);
        access(8, 32'hFFFF_FFFF, 4'hF, 0, 1, "st8_full", 1);
        access(8, 32'hAABB_CCDD, 4'b0101, 0, 1, "st8_lanes", 1);
        access(8, 32'h0, 4'h0, 1, 0, "ld8", 1);
        access(1, 32'h0, 4'h0, 1, 0, "ld_misaligned", 1);
        access(32'h100, 32'h5, 4'hF, 0, 1, "st_out_of_range", 1);
        access(0, 32'h0, 4'h0, 1, 0, "ld0", 1);
        access(12, 32'h1234_5678, 4'hF, 1, 1, "conflict12", 1);
        access(12, 32'h0, 4'h0, 1, 0, "ld12", 1);
        access(20, 32'h0, 4'h0, 0, 1, "st20_be0", 1);
        access(20, 32'h0, 4'h0, 1, 0, "ld20", 1);
        drain();
        check("lanes_word2", model_word(8),
`ifdef DMEM_BYTE_WRITE_EN
              32'hFFBB_FFDD);
`else
              32'hAABB_CCDD);
`endif

        for (int n = 0; n < 150; n++) begin
            int r;
            r  = $urandom_range(0, 9);
            a  = $urandom_range(0, DEP - 1) * 4;
            if (r == 0) a = a | 32'($urandom_range(1, 3));
            if (r == 1) a = $urandom | 32'h100;
            wd = $urandom;
            rd = 1'($urandom);
            wr = !rd || ($urandom_range(0, 7) == 0);
            access(a, wd, 4'($urandom), rd, wr, "rand", 1);
        end
        drain();

        // Reset in the middle of a store: no commit, no done pulse, readData cleared.
        old4 = model_word(16);
        access(16, ~old4, 4'hF, 0, 1, "st16_abort", 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; MemRead = 0; MemWrite = 0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_readData", readData, 32'd0);
        last_rd = '0;
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        access(16, 32'h0, 4'h0, 1, 0, "ld16_after_abort", 1);
        drain();
        check("word4_kept", model_word(16), old4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
